// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port RAM (asynchronous read, posedge write) between an
// instruction-fetch port (read only) and a data-memory port (load/store).
// Grants are combinational, so an access is performed in the cycle its
// request wins. The response (rvalid pulse plus read data) is registered
// and appears one cycle after the grant.
//
// Optional feature (macro MEM_ARB_STARVE_GUARD_EN):
//   defined   - data wins ties by default. If fetch is denied for
//               STARVE_LIMIT consecutive cycles, fetch wins the next tie.
//               After that fetch grant, data has priority again.
//   undefined - data always wins ties (fixed priority). No priority state
//               and no starve counter are built.
//
// Parameters
//   STARVE_LIMIT  consecutive denied fetch cycles before fetch is forced (1..15)
//
// Ports
//   clk, reset                       clock, asynchronous active-high reset
//   if_req/if_addr                   fetch request and word address
//   if_gnt/if_rdata/if_rvalid        fetch grant (comb), data, valid pulse
//   dm_req/dm_we/dm_addr/dm_wdata    data request, store flag, addr, wdata
//   dm_gnt/dm_rdata/dm_rvalid        data grant (comb), load data, valid pulse
//   ram_addr/ram_load/ram_inp        RAM address, write enable, write data
//   ram_outp                         RAM asynchronous read data
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_gnt,
    output logic [15:0] if_rdata,
    output logic        if_rvalid,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic        dm_gnt,
    output logic [15:0] dm_rdata,
    output logic        dm_rvalid,
    output logic [15:0] ram_addr,
    output logic        ram_load,
    output logic [15:0] ram_inp,
    input  logic [15:0] ram_outp
);

    logic        w_if_gnt;
    logic        w_dm_gnt;
    logic [15:0] r_if_rdata;
    logic        r_if_rvalid;
    logic [15:0] r_dm_rdata;
    logic        r_dm_rvalid;

`ifdef MEM_ARB_STARVE_GUARD_EN
    typedef enum logic {
        DM_FIRST = 1'b0,
        IF_FIRST = 1'b1
    } pri_t;

    localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

    pri_t       r_pri;
    pri_t       w_pri_nxt;
    logic [3:0] r_starve;
    logic [3:0] w_starve_nxt;

    // Priority state and starve counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pri    <= DM_FIRST;
            r_starve <= 4'd0;
        end else begin
            r_pri    <= w_pri_nxt;
            r_starve <= w_starve_nxt;
        end
    end

    // Grant selection, starve count update and priority next state
    always_comb begin
        w_if_gnt     = 1'b0;
        w_dm_gnt     = 1'b0;
        w_starve_nxt = 4'd0;
        w_pri_nxt    = r_pri;

        // Grants are suppressed during reset so nothing reaches the RAM
        if (reset) begin
            w_if_gnt = 1'b0;
            w_dm_gnt = 1'b0;
        end else begin
            case (r_pri)
                IF_FIRST: begin
                    w_if_gnt = if_req;
                    w_dm_gnt = dm_req & ~if_req;
                end
                DM_FIRST: begin
                    w_dm_gnt = dm_req;
                    w_if_gnt = if_req & ~dm_req;
                end
                default: begin
                    w_dm_gnt = dm_req;
                    w_if_gnt = if_req & ~dm_req;
                end
            endcase
        end

        // Count only cycles where fetch asks and loses; saturate at the limit
        if (if_req && !w_if_gnt) begin
            if (r_starve >= LP_LIMIT) begin
                w_starve_nxt = LP_LIMIT;
            end else begin
                w_starve_nxt = r_starve + 4'd1;
            end
        end else begin
            w_starve_nxt = 4'd0;
        end

        case (r_pri)
            DM_FIRST: begin
                if (w_starve_nxt == LP_LIMIT) begin
                    w_pri_nxt = IF_FIRST;
                end else begin
                    w_pri_nxt = DM_FIRST;
                end
            end
            IF_FIRST: begin
                if (w_if_gnt) begin
                    w_pri_nxt = DM_FIRST;
                end else begin
                    w_pri_nxt = IF_FIRST;
                end
            end
            default: begin
                w_pri_nxt = DM_FIRST;
            end
        endcase
    end
`else
    // The limit has no effect in the fixed-priority build
    logic [3:0] w_unused_limit;
    assign w_unused_limit = 4'(STARVE_LIMIT);

    // Fixed priority: data always wins a tie; no grants during reset
    always_comb begin
        w_if_gnt = 1'b0;
        w_dm_gnt = 1'b0;
        if (reset) begin
            w_if_gnt = 1'b0;
            w_dm_gnt = 1'b0;
        end else begin
            w_dm_gnt = dm_req;
            w_if_gnt = if_req & ~dm_req;
        end
    end
`endif

    // Response registers: one-cycle rvalid pulses and captured read data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_if_rdata  <= 16'h0000;
            r_if_rvalid <= 1'b0;
            r_dm_rdata  <= 16'h0000;
            r_dm_rvalid <= 1'b0;
        end else begin
            r_if_rvalid <= w_if_gnt;
            r_dm_rvalid <= w_dm_gnt;
            if (w_if_gnt) begin
                r_if_rdata <= ram_outp;
            end
            // Stores acknowledge without disturbing the last load data
            if (w_dm_gnt && !dm_we) begin
                r_dm_rdata <= ram_outp;
            end
        end
    end

    assign if_gnt    = w_if_gnt;
    assign dm_gnt    = w_dm_gnt;
    // Idle cycles park the RAM address on the fetch address
    assign ram_addr  = w_dm_gnt ? dm_addr : if_addr;
    assign ram_load  = w_dm_gnt & dm_we;
    assign ram_inp   = dm_wdata;
    assign if_rdata  = r_if_rdata;
    assign if_rvalid = r_if_rvalid;
    assign dm_rdata  = r_dm_rdata;
    assign dm_rvalid = r_dm_rvalid;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter with a small behavioural RAM model
// (asynchronous read, write on posedge when ram_load). Inputs change 1 ns
// after posedge; combinational outputs are checked at negedge and
// registered outputs 1 ns after posedge. Expected values are hand-computed.
// Build with MEM_ARB_STARVE_GUARD_EN defined to check the starvation guard.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_gnt;
    logic [15:0] if_rdata;
    logic        if_rvalid;
    logic        dm_req;
    logic        dm_we;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic        dm_gnt;
    logic [15:0] dm_rdata;
    logic        dm_rvalid;
    logic [15:0] ram_addr;
    logic        ram_load;
    logic [15:0] ram_inp;
    logic [15:0] ram_outp;

    logic [15:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rdata  (if_rdata),
        .if_rvalid (if_rvalid),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_rdata  (dm_rdata),
        .dm_rvalid (dm_rvalid),
        .ram_addr  (ram_addr),
        .ram_load  (ram_load),
        .ram_inp   (ram_inp),
        .ram_outp  (ram_outp)
    );

    // RAM model
    assign ram_outp = mem[ram_addr[7:0]];
    always @(posedge clk) begin
        if (ram_load) mem[ram_addr[7:0]] <= ram_inp;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic after_pos();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit exp_if;

        for (int k = 0; k < 256; k++) mem[k] = 16'h0000;
        mem[8'h10] = 16'hABCD;

        // Reset with both requests asserted: everything must stay quiet
        reset    = 1'b1;
        if_req   = 1'b1;
        if_addr  = 16'h0010;
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 16'h0050;
        dm_wdata = 16'hFFFF;
        after_pos();
        after_pos();
        chk("rst_if_gnt",    16'(if_gnt),    16'h0000);
        chk("rst_dm_gnt",    16'(dm_gnt),    16'h0000);
        chk("rst_ram_load",  16'(ram_load),  16'h0000);
        chk("rst_if_rvalid", 16'(if_rvalid), 16'h0000);
        chk("rst_dm_rvalid", 16'(dm_rvalid), 16'h0000);
        chk("rst_if_rdata",  if_rdata,       16'h0000);
        chk("rst_dm_rdata",  dm_rdata,       16'h0000);
        chk("rst_no_write",  mem[8'h50],     16'h0000);

        // Fetch alone right after reset release: grant same cycle
        reset  = 1'b0;
        dm_req = 1'b0;
        dm_we  = 1'b0;
        @(negedge clk);
        chk("f_if_gnt",   16'(if_gnt), 16'h0001);
        chk("f_dm_gnt",   16'(dm_gnt), 16'h0000);
        chk("f_ram_addr", ram_addr,    16'h0010);
        after_pos();
        chk("f_if_rvalid", 16'(if_rvalid), 16'h0001);
        chk("f_if_rdata",  if_rdata,       16'hABCD);

        // Store 0x1234 to 0x0020
        if_req   = 1'b0;
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 16'h0020;
        dm_wdata = 16'h1234;
        @(negedge clk);
        chk("st_dm_gnt",   16'(dm_gnt),   16'h0001);
        chk("st_if_gnt",   16'(if_gnt),   16'h0000);
        chk("st_ram_load", 16'(ram_load), 16'h0001);
        chk("st_ram_addr", ram_addr,      16'h0020);
        chk("st_ram_inp",  ram_inp,       16'h1234);
        after_pos();
        chk("st_dm_rvalid", 16'(dm_rvalid), 16'h0001);
        chk("st_if_rvalid", 16'(if_rvalid), 16'h0000);
        chk("st_rdata_hold", dm_rdata,      16'h0000);

        // Load back from 0x0020 the very next cycle
        dm_we = 1'b0;
        @(negedge clk);
        chk("ld_dm_gnt",   16'(dm_gnt),   16'h0001);
        chk("ld_ram_load", 16'(ram_load), 16'h0000);
        after_pos();
        chk("ld_dm_rvalid", 16'(dm_rvalid), 16'h0001);
        chk("ld_dm_rdata",  dm_rdata,       16'h1234);

        // Idle: RAM address parks on if_addr, pulses end
        dm_req  = 1'b0;
        if_addr = 16'h0055;
        @(negedge clk);
        chk("idle_ram_addr", ram_addr,      16'h0055);
        chk("idle_if_gnt",   16'(if_gnt),   16'h0000);
        chk("idle_dm_gnt",   16'(dm_gnt),   16'h0000);
        chk("idle_ram_load", 16'(ram_load), 16'h0000);
        after_pos();
        chk("idle_dm_rvalid", 16'(dm_rvalid), 16'h0000);
        chk("idle_dm_rdata",  dm_rdata,       16'h1234);

        // Both requests held 10 cycles
        if_req  = 1'b1;
        if_addr = 16'h0010;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 16'h0020;
        for (int i = 0; i < 10; i++) begin
            exp_if = GUARD && (i == 4 || i == 9);
            @(negedge clk);
            chk($sformatf("both_if_gnt_%0d", i), 16'(if_gnt), 16'(exp_if));
            chk($sformatf("both_dm_gnt_%0d", i), 16'(dm_gnt), 16'(!exp_if));
            chk($sformatf("both_addr_%0d", i), ram_addr, exp_if ? 16'h0010 : 16'h0020);
            after_pos();
            chk($sformatf("both_if_rv_%0d", i), 16'(if_rvalid), 16'(exp_if));
            chk($sformatf("both_dm_rv_%0d", i), 16'(dm_rvalid), 16'(!exp_if));
        end

        // Reset pulsed during a granted store to 0x0030
        if_req   = 1'b0;
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 16'h0030;
        dm_wdata = 16'hBEEF;
        @(negedge clk);
        chk("ra_dm_gnt",   16'(dm_gnt),   16'h0001);
        chk("ra_ram_load", 16'(ram_load), 16'h0001);
        #1;
        reset = 1'b1;
        #1;
        chk("ra_gnt_off",   16'(dm_gnt),    16'h0000);
        chk("ra_load_off",  16'(ram_load),  16'h0000);
        chk("ra_if_rdata",  if_rdata,       16'h0000);
        chk("ra_dm_rdata",  dm_rdata,       16'h0000);
        chk("ra_if_rvalid", 16'(if_rvalid), 16'h0000);
        chk("ra_dm_rvalid", 16'(dm_rvalid), 16'h0000);
        after_pos();
        reset  = 1'b0;
        dm_req = 1'b0;
        dm_we  = 1'b0;
        chk("ra_mem30",      mem[8'h30],     16'h0000);
        chk("ra_dm_rvalid2", 16'(dm_rvalid), 16'h0000);
        after_pos();
        chk("ra_dm_rvalid3", 16'(dm_rvalid), 16'h0000);
        chk("ra_mem30_b",    mem[8'h30],     16'h0000);

        // Alternating single requests: each granted immediately
        for (int i = 0; i < 8; i++) begin
            if_req  = (i % 2 == 0);
            dm_req  = (i % 2 == 1);
            dm_we   = 1'b0;
            dm_addr = 16'h0020;
            if_addr = 16'h0010;
            @(negedge clk);
            chk($sformatf("alt_if_gnt_%0d", i), 16'(if_gnt), 16'(i % 2 == 0));
            chk($sformatf("alt_dm_gnt_%0d", i), 16'(dm_gnt), 16'(i % 2 == 1));
            after_pos();
            if (i % 2 == 0) begin
                chk($sformatf("alt_if_rv_%0d", i), 16'(if_rvalid), 16'h0001);
                chk($sformatf("alt_if_rd_%0d", i), if_rdata,       16'hABCD);
            end else begin
                chk($sformatf("alt_dm_rv_%0d", i), 16'(dm_rvalid), 16'h0001);
                chk($sformatf("alt_dm_rd_%0d", i), dm_rdata,       16'h1234);
            end
        end

        if_req = 1'b0;
        dm_req = 1'b0;
        after_pos();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch is forced to win (1..15).
REQ-002 Port: clk  input  1  sole clock; all state changes on posedge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: if_req  input  1  instruction-fetch read request; held with if_addr until if_gnt.
REQ-005 Port: if_addr  input  16  fetch word address.
REQ-006 Port: if_gnt  output  1  fetch access performed this cycle (combinational).
REQ-007 Port: if_rdata  output  16  registered fetch read data.
REQ-008 Port: if_rvalid  output  1  if_rdata valid; one-cycle pulse.
REQ-009 Port: dm_req  input  1  data-memory request; held with dm_we/dm_addr/dm_wdata until dm_gnt.
REQ-010 Port: dm_we  input  1  1 = store, 0 = load.
REQ-011 Port: dm_addr  input  16  data word address.
REQ-012 Port: dm_wdata  input  16  store data.
REQ-013 Port: dm_gnt  output  1  data access performed this cycle (combinational).
REQ-014 Port: dm_rdata  output  16  registered load data.
REQ-015 Port: dm_rvalid  output  1  load data valid / store acknowledged; one-cycle pulse.
REQ-016 Port: ram_addr  output  16  address to the single-port RAM.
REQ-017 Port: ram_load  output  1  RAM write enable, sampled by the RAM on posedge clk.
REQ-018 Port: ram_inp  output  16  RAM write data.
REQ-019 Port: ram_outp  input  16  RAM asynchronous read data for ram_addr.

Function
REQ-020 At most one of if_gnt, dm_gnt SHALL be high in any cycle; a grant is given only to an asserted request.
REQ-021 Priority state pri SHALL be DM_FIRST or IF_FIRST; in DM_FIRST a simultaneous request grants dm, in IF_FIRST it grants if.
REQ-022 Starve counter SHALL increment (saturating at STARVE_LIMIT) on each cycle with if_req=1 and if_gnt=0, and clear on any cycle with if_gnt=1 or if_req=0.
REQ-023 pri SHALL move DM_FIRST->IF_FIRST at the posedge where the counter reaches STARVE_LIMIT, and IF_FIRST->DM_FIRST at the posedge following an if_gnt.
REQ-024 ram_addr SHALL equal the granted requester's address; with no grant it SHALL hold if_addr; value is passed unmodified (no range check).
REQ-025 ram_load SHALL equal dm_gnt & dm_we; ram_inp SHALL equal dm_wdata at all times; ram_load SHALL be 0 while reset=1.
REQ-026 On posedge with if_gnt=1: if_rdata <= ram_outp, if_rvalid <= 1; otherwise if_rvalid <= 0 and if_rdata holds.
REQ-027 On posedge with dm_gnt=1: dm_rvalid <= 1; dm_rdata <= ram_outp only when dm_we=0, else holds; otherwise dm_rvalid <= 0.
REQ-028 Latency SHALL be: grant in the request cycle if it wins, response exactly 1 cycle after grant; back-to-back grants to one requester every cycle SHALL be supported.
REQ-029 A load granted the cycle after a store to the same address SHALL return the stored data.

Reset
REQ-030 While reset=1, regardless of clk: pri=DM_FIRST, starve counter=0, if_rvalid=0, dm_rvalid=0, if_rdata=0, dm_rdata=0, if_gnt=0, dm_gnt=0.
REQ-031 An access granted in the cycle reset asserts SHALL be aborted: no RAM write, no rvalid pulse after deassertion.
REQ-032 First grant SHALL be possible in the first cycle after reset deasserts.

Configuration
REQ-033 With MEM_ARB_STARVE_GUARD_EN defined, REQ-021..023 SHALL apply as written.
REQ-034 Without MEM_ARB_STARVE_GUARD_EN, pri and the counter SHALL be absent and dm SHALL always win simultaneous requests (fixed priority).

Verification
REQ-035 if_req only, if_addr=0x0010, RAM[0x10]=0xABCD -> if_gnt same cycle, if_rvalid=1 and if_rdata=0xABCD next cycle.
REQ-036 dm store addr 0x0020 data 0x1234, then dm load 0x0020 next cycle -> ram_load=1 for one cycle, then dm_rdata=0x1234 with dm_rvalid.
REQ-037 if_req and dm_req held 10 cycles, guard enabled, STARVE_LIMIT=4 -> dm granted cycles 0-3, if granted cycle 4, dm cycle 5; guard disabled -> dm all 10.
REQ-038 Reset pulsed during a granted store to 0x0030 (old 0x0000) -> RAM[0x30] stays 0x0000, no rvalid, all outputs zero during reset.
REQ-039 Alternating if/dm requests only one active per cycle for 8 cycles -> every request granted same cycle, never both gnts high.
